uart_rx_deserializer: RTL and testbench

UART receive framing stage, directly downstream of the serial-input edge detector.
- Consumes the synchronised serial line and its falling-edge pulse.
- Oversamples at 16x using a baud clock-enable and recovers start, data, parity and stop bits.
- Presents one received character per frame with parity, framing and break status to the RX FIFO logic.

---
 rtl/uart_pkg.sv | 30 +++
 rtl/uart_rx_bitsampler.sv | 54 +++++
 rtl/uart_rx_deserializer.sv | 146 ++++++++++++++
 tb/tb_uart_rx_deserializer.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path: FSM state encoding,
// oversampling constants, word-length encodings and helpers.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_PAR   = 3'd3,
    ST_STOP  = 3'd4,
    ST_MWAIT = 3'd5
  } rx_state_e;

  // 16 RXCLK pulses per bit; the counter is 4 bits wide and wraps 15->0.
  localparam int OVERSAMPLE   = 16;
  // Mid-bit sample position; the majority voter uses 7, 8 and 9.
  localparam int SAMPLE_POINT = 7;
  localparam int MAJ_LAST     = 9;

  localparam logic [1:0] WLS_5 = 2'b00;
  localparam logic [1:0] WLS_6 = 2'b01;
  localparam logic [1:0] WLS_7 = 2'b10;
  localparam logic [1:0] WLS_8 = 2'b11;

  // Number of data bits for a word-length select code.
  function automatic logic [3:0] data_bits(input logic [1:0] wls);
    return 4'd5 + {2'b00, wls};
  endfunction

endpackage

// File: rtl/uart_rx_bitsampler.sv
// Oversample counter and bit sampler for the UART receiver.
// Optional build macro: UART_RX_MAJORITY_EN (2-of-3 vote at counts 7/8/9,
// sample strobe moves to count 9). Default: single sample at count 7.
module uart_rx_bitsampler
  import uart_pkg::*;
(
  input  logic CLK,
  input  logic RST,
  input  logic RXCLK,
  input  logic SIN,
  input  logic clr_i,
  output logic bit_o,
  output logic sample_o,
  output logic wrap_o
);

  localparam logic [3:0] LAST_CNT = 4'(OVERSAMPLE - 1);

  logic [3:0] cnt_q, cnt_d;

`ifdef UART_RX_MAJORITY_EN
  localparam logic [3:0] SMP_CNT = 4'(MAJ_LAST);
  logic s0_q, s1_q;

  // Capture the first two votes; the third is the live line at count 9.
  always_ff @(posedge CLK) begin
    if (RXCLK && cnt_q == 4'(SAMPLE_POINT))     s0_q <= SIN;
    if (RXCLK && cnt_q == 4'(SAMPLE_POINT + 1)) s1_q <= SIN;
  end

  assign bit_o = (s0_q & s1_q) | (s0_q & SIN) | (s1_q & SIN);
`else
  localparam logic [3:0] SMP_CNT = 4'(SAMPLE_POINT);

  assign bit_o = SIN;
`endif

  // Counter advances only on the baud enable; cleared while the FSM idles.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)      cnt_d = '0;
    else if (RXCLK) cnt_d = cnt_q + 4'd1;
  end

  // Oversample counter register.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign sample_o = RXCLK & ~clr_i & (cnt_q == SMP_CNT);
  assign wrap_o   = RXCLK & ~clr_i & (cnt_q == LAST_CNT);

endmodule

// File: rtl/uart_rx_deserializer.sv
// UART receive framing stage: start/data/parity/stop recovery from a 16x
// oversampled serial line, with parity, framing and break status.
// Optional build macro: UART_RX_MAJORITY_EN (see uart_rx_bitsampler).
module uart_rx_deserializer
  import uart_pkg::*;
(
  input  logic       CLK,
  input  logic       RST,
  input  logic       RXCLK,
  input  logic       RXCLEAR,
  input  logic       SIN,
  input  logic       SIN_FE,
  input  logic [1:0] WLS,
  input  logic       PEN,
  input  logic       EPS,
  input  logic       SP,
  output logic [7:0] DOUT,
  output logic       PE,
  output logic       FE,
  output logic       BI,
  output logic       RXFINISHED
);

  rx_state_e  state_q, state_d;
  logic [3:0] idx_q, idx_d;
  logic [7:0] sh_q, sh_d;
  logic       par_q, par_d;
  logic [7:0] dout_q, dout_d;
  logic       pe_q, pe_d, fe_q, fe_d, bi_q, bi_d, fin_q, fin_d;

  logic       smp_bit, smp_stb, wrap_stb, cnt_clr;
  logic [7:0] data_rj;
  logic       par_exp;

  // Bits arrive LSB-first into the top of sh_q; shift down to right-justify.
  function automatic logic [7:0] rjust(input logic [7:0] sh, input logic [1:0] wls);
    return sh >> (2'd3 - wls);
  endfunction

  // Stick parity forces ~EPS; otherwise even (EPS=1) or odd (EPS=0).
  function automatic logic exp_parity(input logic [7:0] d, input logic eps, input logic sp);
    return sp ? ~eps : (^d) ^ ~eps;
  endfunction

  assign cnt_clr = (state_q == ST_IDLE) | (state_q == ST_MWAIT) | RXCLEAR;
  assign data_rj = rjust(sh_q, WLS);
  assign par_exp = exp_parity(data_rj, EPS, SP);

  uart_rx_bitsampler u_sampler (
    .CLK      (CLK),
    .RST      (RST),
    .RXCLK    (RXCLK),
    .SIN      (SIN),
    .clr_i    (cnt_clr),
    .bit_o    (smp_bit),
    .sample_o (smp_stb),
    .wrap_o   (wrap_stb)
  );

  // Frame sequencing, data shifting and status evaluation.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    sh_d    = sh_q;
    par_d   = par_q;
    dout_d  = dout_q;
    pe_d    = pe_q;
    fe_d    = fe_q;
    bi_d    = bi_q;
    fin_d   = 1'b0;
    unique case (state_q)
      ST_IDLE: if (SIN_FE) state_d = ST_START;
      ST_START: begin
        sh_d  = '0;
        idx_d = '0;
        if (smp_stb && smp_bit) state_d = ST_IDLE;
        else if (wrap_stb)      state_d = ST_DATA;
      end
      ST_DATA: begin
        if (smp_stb) begin
          sh_d  = {smp_bit, sh_q[7:1]};
          idx_d = idx_q + 4'd1;
        end
        // >= keeps the FSM moving if WLS shrinks mid-frame.
        if (wrap_stb && idx_q >= data_bits(WLS)) state_d = PEN ? ST_PAR : ST_STOP;
      end
      ST_PAR: begin
        if (smp_stb)  par_d   = smp_bit;
        if (wrap_stb) state_d = ST_STOP;
      end
      ST_STOP: begin
        if (smp_stb) begin
          dout_d  = data_rj;
          pe_d    = PEN & (par_q != par_exp);
          fe_d    = ~smp_bit;
          bi_d    = (data_rj == 8'h00) & (~par_q | ~PEN) & ~smp_bit;
          fin_d   = 1'b1;
          // Leave half a bit early on a good stop bit so the next start edge is caught.
          state_d = smp_bit ? ST_IDLE : ST_MWAIT;
        end
      end
      ST_MWAIT: if (SIN) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
    if (RXCLEAR) begin
      state_d = ST_IDLE;
      fin_d   = 1'b0;
      dout_d  = dout_q;
      pe_d    = pe_q;
      fe_d    = fe_q;
      bi_d    = bi_q;
    end
  end

  // State, datapath and status registers.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      sh_q    <= '0;
      par_q   <= 1'b0;
      dout_q  <= '0;
      pe_q    <= 1'b0;
      fe_q    <= 1'b0;
      bi_q    <= 1'b0;
      fin_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      sh_q    <= sh_d;
      par_q   <= par_d;
      dout_q  <= dout_d;
      pe_q    <= pe_d;
      fe_q    <= fe_d;
      bi_q    <= bi_d;
      fin_q   <= fin_d;
    end
  end

  assign DOUT       = dout_q;
  assign PE         = pe_q;
  assign FE         = fe_q;
  assign BI         = bi_q;
  assign RXFINISHED = fin_q;

endmodule

// File: tb/tb_uart_rx_deserializer.sv
// Directed bench for uart_rx_deserializer: frames are driven at 16 RXCLK
// pulses per bit, one RXCLK pulse every two CLK cycles.
module tb_uart_rx_deserializer;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       RXCLK = 1'b0;
  logic       RXCLEAR = 1'b0;
  logic       SIN = 1'b1;
  logic       SIN_FE = 1'b0;
  logic [1:0] WLS = 2'b11;
  logic       PEN = 1'b0;
  logic       EPS = 1'b0;
  logic       SP = 1'b0;
  logic [7:0] DOUT;
  logic       PE, FE, BI, RXFINISHED;

  int checks = 0;
  int errors = 0;
  int fin_cnt = 0;
  int f0;

  uart_rx_deserializer dut (
    .CLK        (CLK),
    .RST        (RST),
    .RXCLK      (RXCLK),
    .RXCLEAR    (RXCLEAR),
    .SIN        (SIN),
    .SIN_FE     (SIN_FE),
    .WLS        (WLS),
    .PEN        (PEN),
    .EPS        (EPS),
    .SP         (SP),
    .DOUT       (DOUT),
    .PE         (PE),
    .FE         (FE),
    .BI         (BI),
    .RXFINISHED (RXFINISHED)
  );

  always #5 CLK = ~CLK;

  // Counts every CLK cycle with RXFINISHED high, so a stretched pulse shows up.
  always @(negedge CLK) if (RXFINISHED === 1'b1) fin_cnt++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK); #1 RXCLK = 1'b1;
    @(posedge CLK); #1 RXCLK = 1'b0;
  endtask

  // One bit of 16 ticks; glitch inverts SIN on the 9th tick (counter value 8).
  task automatic send_bit(input logic b, input bit glitch);
    for (int t = 0; t < 16; t++) begin
      SIN = (glitch && t == 8) ? ~b : b;
      tick();
    end
    SIN = b;
  endtask

  task automatic start_edge();
    @(posedge CLK); #1 SIN = 1'b0; SIN_FE = 1'b1;
    @(posedge CLK); #1 SIN_FE = 1'b0;
    send_bit(1'b0, 1'b0);
  endtask

  task automatic send_frame(input logic [7:0] d, input int nb, input bit pen,
                            input logic par, input int nstop, input int gbit);
    start_edge();
    for (int i = 0; i < nb; i++) send_bit(d[i], i == gbit);
    if (pen) send_bit(par, 1'b0);
    for (int s = 0; s < nstop; s++) send_bit(1'b1, 1'b0);
    tick(); tick();
    @(negedge CLK);
  endtask

  initial begin
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    chk("rst_dout", DOUT, 8'h00);
    chk("rst_flags", {PE, FE, BI}, 3'b000);
    chk("rst_fin", RXFINISHED, 1'b0);
    #1 RST = 1'b0;
    tick(); tick();

    // 8N1 0xA5
    WLS = 2'b11; PEN = 1'b0; f0 = fin_cnt;
    send_frame(8'hA5, 8, 0, 1'b0, 1, -1);
    chk("8n1_fin", fin_cnt - f0, 1);
    chk("8n1_dout", DOUT, 8'hA5);
    chk("8n1_flags", {PE, FE, BI}, 3'b000);

    // 7E1 0x41 with wrong parity bit 1 (expected 0)
    WLS = 2'b10; PEN = 1'b1; EPS = 1'b1; SP = 1'b0; f0 = fin_cnt;
    send_frame(8'h41, 7, 1, 1'b1, 1, -1);
    chk("7e1_fin", fin_cnt - f0, 1);
    chk("7e1_dout", DOUT, 8'h41);
    chk("7e1_flags", {PE, FE, BI}, 3'b100);

    // Break: line low for two frame times
    WLS = 2'b11; PEN = 1'b0; f0 = fin_cnt;
    start_edge();
    for (int i = 0; i < 19; i++) send_bit(1'b0, 1'b0);
    @(negedge CLK);
    chk("brk_fin", fin_cnt - f0, 1);
    chk("brk_dout", DOUT, 8'h00);
    chk("brk_flags", {PE, FE, BI}, 3'b011);
    SIN = 1'b1;
    tick(); tick(); tick();
    @(negedge CLK);
    chk("brk_nofin", fin_cnt - f0, 1);
    f0 = fin_cnt;
    send_frame(8'h5A, 8, 0, 1'b0, 1, -1);
    chk("brk_rec_dout", DOUT, 8'h5A);
    chk("brk_rec_flags", {PE, FE, BI, 5'(fin_cnt - f0)}, {3'b000, 5'd1});

    // Four-tick glitch on idle line -> false start
    f0 = fin_cnt;
    @(posedge CLK); #1 SIN = 1'b0; SIN_FE = 1'b1;
    @(posedge CLK); #1 SIN_FE = 1'b0;
    repeat (4) tick();
    SIN = 1'b1;
    repeat (40) tick();
    @(negedge CLK);
    chk("glitch_fin", fin_cnt - f0, 0);
    chk("glitch_dout", DOUT, 8'h5A);

    // RXCLEAR during data bit 3, then a clean 0x3C frame
    f0 = fin_cnt;
    start_edge();
    for (int i = 0; i < 3; i++) send_bit(1'b1, 1'b0);
    SIN = 1'b0;
    repeat (5) tick();
    @(posedge CLK); #1 RXCLEAR = 1'b1;
    @(posedge CLK); #1 RXCLEAR = 1'b0;
    SIN = 1'b1;
    repeat (200) tick();
    @(negedge CLK);
    chk("clr_fin", fin_cnt - f0, 0);
    chk("clr_dout", DOUT, 8'h5A);
    send_frame(8'h3C, 8, 0, 1'b0, 1, -1);
    chk("clr_rec_fin", fin_cnt - f0, 1);
    chk("clr_rec_dout", DOUT, 8'h3C);

    // Stick parity: expected parity bit 1, 0 sent -> PE; zero data but good stop -> no BI
    WLS = 2'b11; PEN = 1'b1; SP = 1'b1; EPS = 1'b0;
    send_frame(8'h00, 8, 1, 1'b0, 1, -1);
    chk("stick_dout", DOUT, 8'h00);
    chk("stick_flags", {PE, FE, BI}, 3'b100);

    // 5O2 0x15 parity 0, with a one-tick inversion at count 8 of bit 2
    WLS = 2'b00; PEN = 1'b1; EPS = 1'b0; SP = 1'b0; f0 = fin_cnt;
    send_frame(8'h15, 5, 1, 1'b0, 2, 2);
    chk("5o2_fin", fin_cnt - f0, 1);
    chk("5o2_dout", DOUT, 8'h15);
    chk("5o2_flags", {PE, FE, BI}, 3'b000);

    // Asynchronous reset mid-frame
    start_edge();
    send_bit(1'b1, 1'b0);
    repeat (3) tick();
    #2 RST = 1'b1;
    #1;
    chk("arst_dout", DOUT, 8'h00);
    chk("arst_flags", {PE, FE, BI, RXFINISHED}, 4'b0000);
    @(posedge CLK); #1 RST = 1'b0; SIN = 1'b1;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
